// File: rtl/wl_sync_pkg.sv
// Shared helpers for clock-domain-crossing input blocks: counter sizing and parameter sanity.
// Pure elaboration-time content; no logic, no latency, no backpressure.
package wl_sync_pkg;

    localparam int SYNC_MIN_STAGES = 2;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit cfg_ok(input int stages, input int filt);
        return (stages >= SYNC_MIN_STAGES) && (filt >= 1);
    endfunction

endpackage

// File: rtl/wl_sync_filt_if.sv
// Conditioner bundle: raw asynchronous inputs in, filtered level and edge events out.
// Plain wires only; no flow control, every output is valid every cycle.
interface wl_sync_filt_if #(
    parameter int CH = 8
);
    logic [CH-1:0] din;
    logic [CH-1:0] dout;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic          chg;

    modport master (
        output din,
        input  dout,
        input  rise,
        input  fall,
        input  chg
    );

    modport slave (
        input  din,
        output dout,
        output rise,
        output fall,
        output chg
    );
endinterface

// File: rtl/wl_sync_filt_ch.sv
// One channel: STAGES-flop synchroniser, FILT-cycle stability filter, registered edge pulses.
// Latency STAGES-1+FILT edges from the first sampling edge; no backpressure (free-running).
module wl_sync_filt_ch
    import wl_sync_pkg::*;
#(
    parameter int   STAGES  = 2,
    parameter int   FILT    = 4,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic evt
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
    logic s_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
        end
    end

    assign s_out = sync_q[STAGES-1];

    if (FILT == 1) begin : g_nofilt
        assign evt = (s_out != dout);

        always_ff @(posedge clk) begin
            if (rst) begin
                dout <= RST_VAL;
                rise <= 1'b0;
                fall <= 1'b0;
            end else begin
                dout <= s_out;
                rise <= s_out & ~dout;
                fall <= ~s_out & dout;
            end
        end
    end else begin : g_filt
        localparam int CW = clog2_min1(FILT);
        logic [CW-1:0] cnt;
        logic          diff;

        assign diff = (s_out != dout);
        // The level is accepted on the FILT-th consecutive disagreeing cycle.
        assign evt  = diff && (cnt == CW'(FILT - 1));

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt  <= '0;
                dout <= RST_VAL;
                rise <= 1'b0;
                fall <= 1'b0;
            end else begin
                rise <= evt & s_out;
                fall <= evt & ~s_out;
                if (!diff || evt) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                if (evt) begin
                    dout <= s_out;
                end
            end
        end
    end

endmodule

// File: rtl/wl_sync_filt.sv
// Multi-channel async input conditioner: per-channel sync + deglitch + rise/fall, plus any-change flag.
// Latency STAGES-1+FILT edges after din is first sampled; no backpressure.
module wl_sync_filt
    import wl_sync_pkg::*;
#(
    parameter int            CH      = 8,
    parameter int            STAGES  = 2,
    parameter int            FILT    = 4,
    parameter logic [CH-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    wl_sync_filt_if.slave bus
);

    logic [CH-1:0] evt;

    if (!cfg_ok(STAGES, FILT)) begin : g_cfg_err
        $error("wl_sync_filt: STAGES must be >= 2 and FILT >= 1");
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        wl_sync_filt_ch #(
            .STAGES  (STAGES),
            .FILT    (FILT),
            .RST_VAL (RST_VAL[i])
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .din  (bus.din[i]),
            .dout (bus.dout[i]),
            .rise (bus.rise[i]),
            .fall (bus.fall[i]),
            .evt  (evt[i])
        );
    end

    // Built from the channels' pre-register events so chg lands with rise/fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.chg <= 1'b0;
        end else begin
            bus.chg <= |evt;
        end
    end

endmodule
